// File: rtl/sine_table_reader_pkg.sv
// -----------------------------------------------------------------------------
// sine_table_reader_pkg
//   Shared definitions for the sine ROM client and its neighbours in the FFT
//   datapath:
//     - FSM state encodings for sine_table_reader (plain localparams so that
//       older tools and netlist viewers see stable binary codes)
//     - quarter_offset(): address distance of a quarter period, used to turn
//       a sin lookup into a cos lookup
//     - sat_negate_fn(): saturating two's-complement negate for the default
//       12-bit twiddle word, reusable by the butterfly datapath
// -----------------------------------------------------------------------------
package sine_table_reader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ISSUE_COS = 3'd1;
  localparam state_t ST_WAIT      = 3'd2;
  localparam state_t ST_CAP_COS   = 3'd3;
  localparam state_t ST_OUT       = 3'd4;

  // Width of the twiddle word served by the default ROM.
  localparam int unsigned TW_DATA_WIDTH = 32'd12;

  // N/4 for N = 2^addr_width; cos(x) = sin(x + quarter period).
  function automatic int unsigned quarter_offset(input int unsigned addr_width);
    return 32'd1 << (addr_width - 32'd2);
  endfunction

  // -(-2^(W-1)) has no W-bit representation, so it clamps to the most
  // positive value; every other input is plain two's-complement negation.
  function automatic logic signed [TW_DATA_WIDTH-1:0] sat_negate_fn(
    input logic signed [TW_DATA_WIDTH-1:0] x
  );
    logic signed [TW_DATA_WIDTH-1:0] min_val;
    logic signed [TW_DATA_WIDTH-1:0] max_val;
    min_val = {1'b1, {(TW_DATA_WIDTH-1){1'b0}}};
    max_val = {1'b0, {(TW_DATA_WIDTH-1){1'b1}}};
    if (x == min_val) begin
      return max_val;
    end else begin
      return -x;
    end
  endfunction

endpackage

// File: rtl/sine_table_reader_sat_negate.sv
// -----------------------------------------------------------------------------
// sat_negate
//   Combinational saturating negator of configurable width.
//   Ports:
//     din   in  DATA_WIDTH  signed operand
//     dout  out DATA_WIDTH  -din, with -(-2^(DATA_WIDTH-1)) clamped to
//                           2^(DATA_WIDTH-1)-1
// -----------------------------------------------------------------------------
module sat_negate
  import sine_table_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // Negate, clamping the single overflowing input.
  always_comb begin
    dout = MAX_VAL;
    if (din == MIN_VAL) begin
      dout = MAX_VAL;
    end else begin
      dout = -din;
    end
  end

endmodule

// File: rtl/sine_table_reader.sv
// -----------------------------------------------------------------------------
// sine_table_reader
//   Client of the single-port sine ROM (full period, signed words). For each
//   accepted twiddle index k it reads sin(k) and then sin(k + N/4) = cos(k),
//   and presents {sin, cos} on a valid/ready output. With req_inv set the sin
//   component is negated (saturating) to give the conjugate twiddle.
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   synchronous active-high reset
//     req_valid    in   twiddle request present
//     req_ready    out  request accepted this cycle if req_valid (IDLE only)
//     req_k        in   twiddle index k (sampled at acceptance only)
//     req_inv      in   conjugate request (sampled at acceptance only)
//     rom_addr     out  registered ROM address
//     rom_rd_data  in   ROM read data, ROM_LAT clocks after rom_addr sampled
//     tw_valid     out  twiddle pair valid
//     tw_ready     in   consumer accepts pair
//     tw_sin       out  signed sin(2*pi*k/N), negated if inv
//     tw_cos       out  signed cos(2*pi*k/N)
//
//   Timing, acceptance at edge E0: rom_addr=k after E0, rom_addr=k+N/4 after
//   E1, sin captured at E(1+ROM_LAT), cos captured and tw_valid set at
//   E(2+ROM_LAT). rom_addr is left on the cos address between requests so
//   the ROM address pins do not toggle needlessly.
// -----------------------------------------------------------------------------
module sine_table_reader
  import sine_table_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12,
  parameter int ROM_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic        [ADDR_WIDTH-1:0] req_k,
  input  logic                         req_inv,
  output logic        [ADDR_WIDTH-1:0] rom_addr,
  input  logic signed [DATA_WIDTH-1:0] rom_rd_data,
  output logic                         tw_valid,
  input  logic                         tw_ready,
  output logic signed [DATA_WIDTH-1:0] tw_sin,
  output logic signed [DATA_WIDTH-1:0] tw_cos
);

  localparam logic [ADDR_WIDTH-1:0] QUARTER  = ADDR_WIDTH'(quarter_offset(ADDR_WIDTH));
  // ROM_LAT is 1..3, so the WAIT counter only ever needs to reach 2.
  localparam logic [1:0]            LAT_LAST = 2'(ROM_LAT - 1);

  state_t                         state;
  logic        [ADDR_WIDTH-1:0]   k_lat;
  logic                           inv_lat;
  logic signed [DATA_WIDTH-1:0]   sin_cap;
  logic        [1:0]              lat_cnt;
  logic signed [DATA_WIDTH-1:0]   sin_neg;

  sat_negate #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat_negate (
    .din  (sin_cap),
    .dout (sin_neg)
  );

  // Request FSM: sequences the two ROM reads and the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      tw_valid  <= 1'b0;
      rom_addr  <= '0;
      tw_sin    <= '0;
      tw_cos    <= '0;
      k_lat     <= '0;
      inv_lat   <= 1'b0;
      sin_cap   <= '0;
      lat_cnt   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            k_lat     <= req_k;
            inv_lat   <= req_inv;
            rom_addr  <= req_k;
            req_ready <= 1'b0;
            state     <= ST_ISSUE_COS;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE_COS: begin
          // Sum is ADDR_WIDTH bits wide, so k + N/4 wraps modulo N for free.
          rom_addr <= k_lat + QUARTER;
          lat_cnt  <= 2'd0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // sin(k) is on rom_rd_data once ROM_LAT-1 extra cycles have passed.
          if (lat_cnt == LAT_LAST) begin
            sin_cap <= rom_rd_data;
            state   <= ST_CAP_COS;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ST_CAP_COS: begin
          tw_cos   <= rom_rd_data;
          tw_sin   <= inv_lat ? sin_neg : sin_cap;
          tw_valid <= 1'b1;
          state    <= ST_OUT;
        end
        ST_OUT: begin
          if (tw_ready) begin
            tw_valid  <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_OUT;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle without output.
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          tw_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_table_reader.sv
// -----------------------------------------------------------------------------
// tb_sine_table_reader
//   Directed bench for sine_table_reader. Two instances share one stimulus
//   path: dut1 with ROM_LAT=1 and dut2 with ROM_LAT=2; 'sel' picks which one
//   the stimulus drives and whose outputs are observed. Each ROM model holds
//   round(2047*sin(2*pi*a/1024)). Expected twiddle pairs are queued when a
//   request is accepted and compared when the pair is handed over.
// -----------------------------------------------------------------------------
module tb_sine_table_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic       req_valid = 1'b0;
  logic [9:0] req_k     = 10'd0;
  logic       req_inv   = 1'b0;
  logic       tw_ready  = 1'b0;

  logic               rv1, rv2, tr1, tr2;
  logic               rr1, rr2, tv1, tv2;
  logic [9:0]         addr1, addr2;
  logic signed [11:0] rd1, rd2, pipe2;
  logic signed [11:0] ts1, ts2, tc1, tc2;

  logic               o_rr, o_tv;
  logic [9:0]         o_addr;
  logic signed [11:0] o_ts, o_tc;

  logic signed [11:0] mem [0:1023];

  typedef struct {
    int s;
    int c;
  } exp_t;
  exp_t q[$];

  int cyc     = 0;
  int acc_cyc = 0;
  int errors  = 0;
  int checks  = 0;

  assign rv1 = req_valid & ~sel;
  assign rv2 = req_valid & sel;
  assign tr1 = tw_ready & ~sel;
  assign tr2 = tw_ready & sel;

  assign o_rr   = sel ? rr2   : rr1;
  assign o_tv   = sel ? tv2   : tv1;
  assign o_addr = sel ? addr2 : addr1;
  assign o_ts   = sel ? ts2   : ts1;
  assign o_tc   = sel ? tc2   : tc1;

  sine_table_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(12), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_k(req_k),
    .req_inv(req_inv), .rom_addr(addr1), .rom_rd_data(rd1), .tw_valid(tv1),
    .tw_ready(tr1), .tw_sin(ts1), .tw_cos(tc1)
  );

  sine_table_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(12), .ROM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2), .req_k(req_k),
    .req_inv(req_inv), .rom_addr(addr2), .rom_rd_data(rd2), .tw_valid(tv2),
    .tw_ready(tr2), .tw_sin(ts2), .tw_cos(tc2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: one and two clocks of read latency.
  always @(posedge clk) rd1 <= mem[addr1];
  always @(posedge clk) begin
    pipe2 <= mem[addr2];
    rd2   <= pipe2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(-r + 0.5);
  endfunction

  function automatic int model_sin(input int k, input bit inv);
    int v;
    v = mem[k];
    if (inv) v = (v == -2048) ? 2047 : -v;
    return v;
  endfunction

  function automatic int model_cos(input int k);
    return mem[(k + 256) % 1024];
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge; ends one cycle after acceptance + 1.
  task automatic issue(input int k, input bit inv, input int es, input int ec,
                       output int waited);
    exp_t e;
    waited    = 0;
    req_valid = 1'b1;
    req_k     = 10'(k);
    req_inv   = inv;
    while (o_rr !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before_accept", o_rr, 1);
    @(posedge clk);
    e.s = es;
    e.c = ec;
    q.push_back(e);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    // Scramble the request inputs: the in-flight request must not see them.
    req_k     = 10'(k) ^ 10'h3ff;
    req_inv   = ~inv;
    check("rom_addr_sin", o_addr, k);
    check("req_ready_busy", o_rr, 0);
    @(negedge clk);
    check("rom_addr_cos", o_addr, (k + 256) % 1024);
  endtask

  task automatic wait_valid(input int lat);
    int guard;
    guard = 0;
    while (o_tv !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("tw_valid_rise", o_tv, 1);
    check("tw_valid_latency", cyc - acc_cyc, 2 + lat);
  endtask

  task automatic handshake();
    exp_t e;
    e.s = 0;
    e.c = 0;
    check("scoreboard_depth", q.size(), 1);
    if (q.size() > 0) e = q.pop_front();
    check("tw_sin", o_ts, e.s);
    check("tw_cos", o_tc, e.c);
    tw_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tw_ready = 1'b0;
    check("tw_valid_after_hs", o_tv, 0);
    check("req_ready_after_hs", o_rr, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, o_rr, 1);
    check({tag, "_tw_valid"}, o_tv, 0);
    check({tag, "_rom_addr"}, o_addr, 0);
    check({tag, "_tw_sin"}, o_ts, 0);
    check({tag, "_tw_cos"}, o_tc, 0);
  endtask

  task automatic watch_quiet(input string tag);
    repeat (8) begin
      @(negedge clk);
      check(tag, o_tv, 0);
    end
  endtask

  initial begin
    int w;
    exp_t bp;
    for (int a = 0; a < 1024; a++) begin
      mem[a] = 12'(rnd(2047.0 * $sin(2.0 * 3.14159265358979 * a / 1024.0)));
    end

    // Power-up reset, both instances.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    #1 check_reset_state("por_lat1");
    sel = 1'b1;
    #1 check_reset_state("por_lat2");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // k=0: sin 0, cos full scale.
    issue(0, 1'b0, 0, 2047, w);
    wait_valid(1);
    handshake();

    // k=768: cos address wraps 1024 -> 0.
    issue(768, 1'b0, -2047, 0, w);
    wait_valid(1);
    handshake();

    // k=256 conjugated.
    issue(256, 1'b1, -2047, 0, w);
    wait_valid(1);
    handshake();

    // Most negative ROM word negates with saturation.
    mem[256] = -12'sd2048;
    issue(256, 1'b1, 2047, 0, w);
    wait_valid(1);
    handshake();
    mem[256] = 12'sd2047;

    // Backpressure with a competing request held on the input.
    issue(100, 1'b0, model_sin(100, 1'b0), model_cos(100), w);
    wait_valid(1);
    bp = q[0];
    req_valid = 1'b1;
    req_k     = 10'd200;
    req_inv   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_tw_valid", o_tv, 1);
      check("bp_tw_sin", o_ts, bp.s);
      check("bp_tw_cos", o_tc, bp.c);
      check("bp_req_ready", o_rr, 0);
      check("bp_rom_addr", o_addr, 356);
      @(negedge clk);
    end
    handshake();
    issue(200, 1'b1, model_sin(200, 1'b1), model_cos(200), w);
    check("bp_accept_next_cycle", w, 0);
    wait_valid(1);
    handshake();

    // Reset while waiting for the ROM.
    issue(300, 1'b0, model_sin(300, 1'b0), model_cos(300), w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_reset_state("rst_wait");
    watch_quiet("rst_wait_no_pulse");

    // Reset during output backpressure.
    issue(50, 1'b0, model_sin(50, 1'b0), model_cos(50), w);
    wait_valid(1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_reset_state("rst_out");
    watch_quiet("rst_out_no_pulse");

    // Two-clock ROM latency.
    sel = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 0, 2047, w);
    wait_valid(2);
    handshake();
    issue(768, 1'b0, -2047, 0, w);
    wait_valid(2);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
